// File: rtl/reply_fm0_tx.sv
// FM0 reply transmitter: latches an RN16/handle payload, optionally appends the
// inverted CRC-16, and emits pilot/preamble/data/CRC/EOS half-symbols at DOUB_BLF.
//
// state   | meaning
// IDLE    | waiting for tx_start, tx_out/tx_en low
// PILOT   | 2*PILOT_BITS half-symbols of FM0 data-0 (trext only)
// PRE     | 12 raw preamble half-symbols, MSB first
// DATA    | 16 payload bits, FM0, MSB first; feeds CRC
// CRC     | 16 inverted CRC bits, FM0, MSB first (crc_en only)
// EOS     | dummy data-1 end-of-signalling bit
// DONE    | one-cycle tx_done pulse, modulator off
module reply_fm0_tx #(
  parameter int          PILOT_BITS = 12,
  parameter logic [11:0] PREAMBLE   = 12'b1101_0010_0011,
  parameter logic [15:0] CRC_PRESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic        tx_sel,
  input  logic [15:0] rn16,
  input  logic [15:0] handle,
  input  logic        crc_en,
  input  logic        trext,
  output logic        tx_out,
  output logic        tx_en,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_PRE, S_DATA, S_CRC, S_EOS, S_DONE
  } state_t;

  localparam logic [6:0] PILOT_LAST = 7'(2 * PILOT_BITS - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        lvl_q, lvl_d;
  logic [15:0] pay_q, pay_d;
  logic [15:0] crc_q, crc_d;
  logic        crc_en_q, crc_en_d;
  logic        trext_q, trext_d;
  logic        cur_bit;
  logic        crc_fb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
      pay_q    <= '0;
      crc_q    <= CRC_PRESET;
      crc_en_q <= 1'b0;
      trext_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      pay_q    <= pay_d;
      crc_q    <= crc_d;
      crc_en_q <= crc_en_d;
      trext_q  <= trext_d;
    end
  end

  // cnt_q counts half-symbols down within a state; odd = first half of a bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pay_d    = pay_q;
    crc_d    = crc_q;
    crc_en_d = crc_en_q;
    trext_d  = trext_q;
    lvl_d    = 1'b0;
    crc_fb   = crc_q[15] ^ pay_q[15];

    unique case (state_q)
      S_DATA:  cur_bit = pay_q[15];
      S_CRC:   cur_bit = ~crc_q[15];
      S_EOS:   cur_bit = 1'b1;
      default: cur_bit = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          pay_d    = tx_sel ? handle : rn16;
          crc_en_d = crc_en;
          trext_d  = trext;
          crc_d    = CRC_PRESET;
          if (trext) begin
            state_d = S_PILOT;
            cnt_d   = PILOT_LAST;
          end else begin
            state_d = S_PRE;
            cnt_d   = 7'd11;
          end
        end
      end
      S_PILOT: begin
        if (cnt_q == '0) begin
          state_d = S_PRE;
          cnt_d   = 7'd11;
        end else cnt_d = cnt_q - 7'd1;
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = 7'd31;
        end else cnt_d = cnt_q - 7'd1;
      end
      S_DATA: begin
        if (cnt_q[0]) crc_d = {crc_q[14:0], 1'b0} ^ ({16{crc_fb}} & 16'h1021);
        else          pay_d = {pay_q[14:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = crc_en_q ? S_CRC : S_EOS;
          cnt_d   = crc_en_q ? 7'd31 : 7'd1;
        end else cnt_d = cnt_q - 7'd1;
      end
      S_CRC: begin
        if (!cnt_q[0]) crc_d = {crc_q[14:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_EOS;
          cnt_d   = 7'd1;
        end else cnt_d = cnt_q - 7'd1;
      end
      S_EOS: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 7'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // level for the half-symbol that will be on the line after this edge
    unique case (state_d)
      S_PRE:                        lvl_d = PREAMBLE[cnt_d[3:0]];
      S_PILOT, S_DATA, S_CRC, S_EOS: lvl_d = cnt_d[0] ? ~lvl_q : (cur_bit ? lvl_q : ~lvl_q);
      default:                      lvl_d = 1'b0;
    endcase
  end

  assign tx_out  = lvl_q;
  assign tx_busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tx_en   = tx_busy;
  assign tx_done = (state_q == S_DONE);

endmodule

// File: tb/tb_reply_fm0_tx.sv
// Bench for reply_fm0_tx: table of frame vectors checked half-symbol by
// half-symbol against a queue of expected levels, plus ignore/reset sequences.
module tb_reply_fm0_tx;

  localparam logic [11:0] PRE = 12'b1101_0010_0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic        tx_sel = 1'b0;
  logic [15:0] rn16 = '0;
  logic [15:0] handle = '0;
  logic        crc_en = 1'b0;
  logic        trext = 1'b0;
  logic        tx_out, tx_en, tx_busy, tx_done;

  reply_fm0_tx dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_sel(tx_sel),
    .rn16(rn16), .handle(handle), .crc_en(crc_en), .trext(trext),
    .tx_out(tx_out), .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [15:0] rn16;
    logic [15:0] handle;
    logic        crc_en;
    logic        trext;
    int          exp_len;
    logic [15:0] exp_pay;
    logic [15:0] exp_crcf;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   exp_q[$];
  bit   m_lvl;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] d);
    logic [15:0] c = 16'hFFFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  task automatic fm0(input bit b);
    m_lvl = ~m_lvl;
    exp_q.push_back(m_lvl);
    if (!b) m_lvl = ~m_lvl;
    exp_q.push_back(m_lvl);
  endtask

  task automatic push_frame(input logic [15:0] pay, input bit ce, input bit te);
    logic [15:0] c;
    m_lvl = 1'b0;
    if (te) for (int i = 0; i < 12; i++) fm0(1'b0);
    for (int k = 11; k >= 0; k--) begin
      m_lvl = PRE[k];
      exp_q.push_back(m_lvl);
    end
    for (int i = 15; i >= 0; i--) fm0(pay[i]);
    if (ce) begin
      c = ~crc16(pay);
      for (int i = 15; i >= 0; i--) fm0(c[i]);
    end
    fm0(1'b1);
  endtask

  task automatic run_frame(input vec_t v, input bit poke);
    int          n_busy = 0;
    int          off;
    bit          got[$];
    bit          e;
    bit          extra = 1'b0;
    logic [15:0] dpay = '0;
    logic [15:0] dcrc = '0;
    push_frame(v.sel ? v.handle : v.rn16, v.crc_en, v.trext);
    tx_sel = v.sel; rn16 = v.rn16; handle = v.handle;
    crc_en = v.crc_en; trext = v.trext; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    while (tx_busy && n_busy < 200) begin
      if (exp_q.size() == 0) chk("tx_out_overrun", 32'(tx_out), 32'hx);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("tx_out[%0d]", n_busy), 32'(tx_out), 32'(e));
      end
      if (!tx_en) chk($sformatf("tx_en[%0d]", n_busy), 32'(tx_en), 32'd1);
      got.push_back(tx_out);
      n_busy++;
      if (poke && n_busy == 20) begin
        rn16 = ~rn16; handle = ~handle; tx_sel = ~tx_sel;
        crc_en = ~crc_en; trext = ~trext; tx_start = 1'b1;
      end else tx_start = 1'b0;
      @(negedge clk);
    end
    chk("busy_len", 32'(n_busy), 32'(v.exp_len));
    chk("done_pulse", 32'(tx_done), 32'd1);
    chk("done_out", 32'({tx_out, tx_en, tx_busy}), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (poke) tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("done_once", 32'(tx_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (tx_busy || tx_done || tx_en || tx_out) extra = 1'b1;
      @(negedge clk);
    end
    chk("idle_after", 32'(extra), 32'd0);
    off = v.trext ? 36 : 12;
    for (int i = 0; i < 16; i++) begin
      dpay = {dpay[14:0], got[off + 2*i] == got[off + 2*i + 1]};
      dcrc = {dcrc[14:0], got[off + 32 + 2*i] == got[off + 32 + 2*i + 1]};
    end
    chk("dec_payload", 32'(dpay), 32'(v.exp_pay));
    if (v.crc_en) chk("dec_crc", 32'(dcrc), 32'(v.exp_crcf));
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 16'h7777, 1'b0, 1'b0, 46, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 46, 16'hFFFF, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 78, 16'h0000, 16'hE2F0};
    vecs[3] = '{1'b0, 16'hA5C3, 16'h0000, 1'b1, 1'b1, 102, 16'hA5C3, ~crc16(16'hA5C3)};
    vecs[4] = '{1'b1, 16'hBEEF, 16'h5A3C, 1'b1, 1'b0, 78, 16'h5A3C, ~crc16(16'h5A3C)};
    vecs[5] = '{1'b0, 16'h8001, 16'h0F0F, 1'b0, 1'b1, 70, 16'h8001, 16'h0000};

    @(negedge clk);
    chk("reset_out", 32'({tx_out, tx_en, tx_busy, tx_done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out", 32'({tx_out, tx_en, tx_busy, tx_done}), 32'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0);

    // inputs and tx_start disturbed mid-frame and in the DONE cycle
    run_frame(vecs[4], 1'b1);

    // reset during DATA, then a clean frame
    tx_sel = 1'b0; rn16 = 16'hA5C3; crc_en = 1'b1; trext = 1'b0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_out", 32'(tx_out), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    begin
      bit dn = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (tx_done) dn = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (tx_done || tx_busy) dn = 1'b1;
      end
      chk("rst_no_done", 32'(dn), 32'd0);
    end
    exp_q.delete();
    run_frame(vecs[3], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
